// File: rtl/embertrail_dmem_seq_if.sv
// Core-side load/store handshake plus the Mem1/Mem2 data bus pins of the Embertrail data memory sequencer.
interface embertrail_dmem_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [DATA_W-1:0] data_rd_bus;
    logic [DATA_W-1:0] data_wr_bus;
    logic [ADDR_W-1:0] data_addr_bus;
    logic              data_mem1_rw;
    logic              data_mem2_rw;
    logic              data1_bus_en;
    logic              data2_bus_en;

    // slave: the sequencer; master: the load/store unit together with the banks
    modport slave (
        input  req, write, addr, wdata, data_rd_bus,
        output ack, rdata, busy, data_wr_bus, data_addr_bus,
               data_mem1_rw, data_mem2_rw, data1_bus_en, data2_bus_en
    );

    modport master (
        output req, write, addr, wdata, data_rd_bus,
        input  ack, rdata, busy, data_wr_bus, data_addr_bus,
               data_mem1_rw, data_mem2_rw, data1_bus_en, data2_bus_en
    );
endinterface

// File: rtl/embertrail_dmem_seq.sv
// Embertrail data memory sequencer: one load/store in flight, bank decode, enables, RW strobes and wait states.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for req; request fields latched on the accepting edge
// S_SETUP  | address, bank enable, RW and store data on the bus
// S_ACCESS | WAIT_CYCLES+1 cycles with the bus held; load data captured at the end
// S_DONE   | bus released, one-cycle ack
module embertrail_dmem_seq #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BANK_SEL_BIT = 16,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    embertrail_dmem_seq_if.slave  bus
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("embertrail_dmem_seq: WAIT_CYCLES must be within 0..15");
        end
        if (BANK_SEL_BIT < 0 || BANK_SEL_BIT >= ADDR_W) begin : g_bad_bank_bit
            $error("embertrail_dmem_seq: BANK_SEL_BIT must address a bit of the address");
        end
    endgenerate

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;

    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] wbus_q, wbus_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic              rw1_q, rw1_d;
    logic              rw2_q, rw2_d;
    logic              en1_q, en1_d;
    logic              en2_q, en2_d;

    logic              bank_sel;

    assign bank_sel = bus.addr[BANK_SEL_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            wbus_q  <= '0;
            abus_q  <= '0;
            rw1_q   <= 1'b0;
            rw2_q   <= 1'b0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            wbus_q  <= wbus_d;
            abus_q  <= abus_d;
            rw1_q   <= rw1_d;
            rw2_q   <= rw2_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
        end
    end

    // Every output is the registered image of its _d value, so bus pins change only on clock edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        wbus_d  = wbus_q;
        abus_d  = abus_q;
        rw1_d   = rw1_q;
        rw2_d   = rw2_q;
        en1_d   = en1_q;
        en2_d   = en2_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d = S_SETUP;
                    wr_d    = bus.write;
                    abus_d  = bus.addr;
                    en1_d   = ~bank_sel;
                    en2_d   = bank_sel;
                    rw1_d   = ~bank_sel & bus.write;
                    rw2_d   = bank_sel & bus.write;
                    wbus_d  = bus.write ? bus.wdata : '0;
                    cnt_d   = WAIT_LD;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                    en1_d   = 1'b0;
                    en2_d   = 1'b0;
                    rw1_d   = 1'b0;
                    rw2_d   = 1'b0;
                    wbus_d  = '0;
                    if (!wr_q) begin
                        rdata_d = bus.data_rd_bus;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.ack           = ack_q;
    assign bus.rdata         = rdata_q;
    assign bus.busy          = busy_q;
    assign bus.data_wr_bus   = wbus_q;
    assign bus.data_addr_bus = abus_q;
    assign bus.data_mem1_rw  = rw1_q;
    assign bus.data_mem2_rw  = rw2_q;
    assign bus.data1_bus_en  = en1_q;
    assign bus.data2_bus_en  = en2_q;

    a_single_bank : assert property (@(posedge clk) disable iff (rst) !(en1_q && en2_q));

endmodule

// File: tb/tb_embertrail_dmem_seq.sv
// Bench for embertrail_dmem_seq: directed vector table, multi-cycle corner sequences and random traffic against a flat memory model.
module tb_embertrail_dmem_seq;

    localparam int W = 2;
    localparam int P = W + 4;
    localparam logic [31:0] BANK_MASK = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    embertrail_dmem_seq_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    embertrail_dmem_seq_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    embertrail_dmem_seq #(
        .ADDR_W(32), .DATA_W(32), .BANK_SEL_BIT(16), .WAIT_CYCLES(W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    embertrail_dmem_seq #(
        .ADDR_W(32), .DATA_W(32), .BANK_SEL_BIT(16), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;
    int n_acc = 0;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_load = 32'h0;

    // Two independent banks, each addressed with the bank-select bit stripped.
    logic [31:0] mem1 [logic [31:0]];
    logic [31:0] mem2 [logic [31:0]];
    logic [31:0] bm_key;

    always @(negedge clk) begin
        bm_key = bus.data_addr_bus & ~BANK_MASK;
        if (bus.data1_bus_en && bus.data_mem1_rw) mem1[bm_key] = bus.data_wr_bus;
        if (bus.data2_bus_en && bus.data_mem2_rw) mem2[bm_key] = bus.data_wr_bus;
        if (bus.data1_bus_en)
            bus.data_rd_bus = mem1.exists(bm_key) ? mem1[bm_key] : 32'h0;
        else if (bus.data2_bus_en)
            bus.data_rd_bus = mem2.exists(bm_key) ? mem2[bm_key] : 32'h0;
        else
            bus.data_rd_bus = $urandom;
    end

    always @(negedge clk) begin
        n_cmp++;
        if (bus.data1_bus_en && bus.data2_bus_en) begin
            n_bad++;
            $display("FAIL bus_en_excl: en1=%b en2=%b, required not both 1", bus.data1_bus_en, bus.data2_bus_en);
        end
        n_cmp++;
        if ((bus.data_mem1_rw && !bus.data1_bus_en) || (bus.data_mem2_rw && !bus.data2_bus_en)) begin
            n_bad++;
            $display("FAIL rw_qualified: rw1=%b en1=%b rw2=%b en2=%b, required rw=0 without en",
                     bus.data_mem1_rw, bus.data1_bus_en, bus.data_mem2_rw, bus.data2_bus_en);
        end
        if (bus.ack === 1'b1) n_ack++;
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk1({nm, "_ack"}, bus.ack, 1'b0);
        chk1({nm, "_busy"}, bus.busy, 1'b0);
        chk1({nm, "_en1"}, bus.data1_bus_en, 1'b0);
        chk1({nm, "_en2"}, bus.data2_bus_en, 1'b0);
        chk1({nm, "_rw1"}, bus.data_mem1_rw, 1'b0);
        chk1({nm, "_rw2"}, bus.data_mem2_rw, 1'b0);
        chk32({nm, "_wbus"}, bus.data_wr_bus, 32'h0);
        chk32({nm, "_abus"}, bus.data_addr_bus, 32'h0);
        chk32({nm, "_rdata"}, bus.rdata, 32'h0);
    endtask

    // One complete access with every cycle of SETUP/ACCESS/DONE checked at its fixed latency.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic bank, input logic [31:0] exp_rd, input string nm);
        logic [31:0] exp_wbus;
        exp_wbus = w ? d : 32'h0;
        @(negedge clk);
        bus.req = 1'b1; bus.write = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; bus.write = ~w; bus.addr = $urandom; bus.wdata = $urandom;
        for (int c = 1; c <= W + 2; c++) begin
            if (c > 1) @(negedge clk);
            chk1({nm, "_en1"}, bus.data1_bus_en, ~bank);
            chk1({nm, "_en2"}, bus.data2_bus_en, bank);
            chk1({nm, "_rw1"}, bus.data_mem1_rw, ~bank & w);
            chk1({nm, "_rw2"}, bus.data_mem2_rw, bank & w);
            chk32({nm, "_abus"}, bus.data_addr_bus, a);
            chk32({nm, "_wbus"}, bus.data_wr_bus, exp_wbus);
            chk1({nm, "_busy"}, bus.busy, 1'b1);
            chk1({nm, "_early_ack"}, bus.ack, 1'b0);
            chk32({nm, "_rdata_prev"}, bus.rdata, last_load);
        end
        @(negedge clk);
        chk1({nm, "_ack"}, bus.ack, 1'b1);
        chk1({nm, "_done_en1"}, bus.data1_bus_en, 1'b0);
        chk1({nm, "_done_en2"}, bus.data2_bus_en, 1'b0);
        chk1({nm, "_done_rw1"}, bus.data_mem1_rw, 1'b0);
        chk1({nm, "_done_rw2"}, bus.data_mem2_rw, 1'b0);
        chk32({nm, "_done_wbus"}, bus.data_wr_bus, 32'h0);
        chk32({nm, "_done_abus"}, bus.data_addr_bus, a);
        chk1({nm, "_done_busy"}, bus.busy, 1'b1);
        chk32({nm, "_rdata"}, bus.rdata, exp_rd);
        @(negedge clk);
        chk1({nm, "_ack_drop"}, bus.ack, 1'b0);
        chk1({nm, "_idle_busy"}, bus.busy, 1'b0);
        chk32({nm, "_rdata_held"}, bus.rdata, exp_rd);
        n_acc++;
        if (w) ref_mem[a] = d;
        last_load = exp_rd;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        bank;
        logic [31:0] rd;
        string       nm;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] ta [0:3*P];
    logic [31:0] td [0:3*P];

    initial begin
        logic        w;
        logic        bank;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, "st_mem1"};
        vecs[1] = '{1'b1, 32'h0001_0020, 32'h1234_5678, 1'b1, 32'h0000_0000, "st_mem2"};
        vecs[2] = '{1'b0, 32'h0001_0020, 32'h0000_0000, 1'b1, 32'h1234_5678, "ld_mem2"};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF, "ld_mem1"};
        vecs[4] = '{1'b1, 32'hFFFF_0010, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF, "st_hi_mem2"};
        vecs[5] = '{1'b0, 32'hFFFE_0010, 32'h0000_0000, 1'b0, 32'h0000_0000, "ld_hi_mem1"};
        vecs[6] = '{1'b0, 32'hFFFF_0010, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, "ld_hi_mem2"};
        vecs[7] = '{1'b1, 32'h0000_0014, 32'h0BAD_F00D, 1'b0, 32'hA5A5_A5A5, "st_keep_rdata"};

        rst = 1'b1;
        bus.req = 1'b0; bus.write = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
        bus0.req = 1'b0; bus0.write = 1'b0; bus0.addr = 32'h0; bus0.wdata = 32'h0;
        bus0.data_rd_bus = 32'h0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i])
            do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].bank, vecs[i].rd, vecs[i].nm);

        // Back-to-back: req held, address/data change every cycle; each access keeps its IDLE-cycle values.
        for (int k = 0; k <= 3 * P; k++) begin
            ta[k] = 32'h0000_0100 + 32'(k * 4);
            ta[k][16] = 1'(k % 2);
            td[k] = $urandom;
        end
        for (int k = 0; k <= 3 * P; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if ((k - 1) % P == W + 2) begin
                    chk1("b2b_ack", bus.ack, 1'b1);
                    chk32("b2b_addr", bus.data_addr_bus, ta[((k - 1) / P) * P]);
                end else begin
                    chk1("b2b_no_ack", bus.ack, 1'b0);
                end
            end
            if (k < 3 * P) begin
                bus.req = 1'b1; bus.write = 1'b1; bus.addr = ta[k]; bus.wdata = td[k];
            end else begin
                bus.req = 1'b0;
            end
        end
        n_acc += 3;
        for (int j = 0; j < 3; j++) ref_mem[ta[j * P]] = td[j * P];
        for (int j = 0; j < 3; j++)
            do_access(1'b0, ta[j * P], 32'h0, ta[j * P][16], td[j * P], "b2b_readback");
        do_access(1'b0, ta[1], 32'h0, ta[1][16], 32'h0, "b2b_skipped");

        // Zero-wait build: load data is whatever the bank drives in the single ACCESS cycle.
        @(negedge clk);
        bus0.req = 1'b1; bus0.write = 1'b0; bus0.addr = 32'h0000_0008;
        @(posedge clk);
        @(negedge clk);
        bus0.req = 1'b0; bus0.addr = $urandom; bus0.data_rd_bus = 32'h1111_1111;
        chk1("w0_setup_en1", bus0.data1_bus_en, 1'b1);
        chk1("w0_setup_en2", bus0.data2_bus_en, 1'b0);
        chk1("w0_setup_ack", bus0.ack, 1'b0);
        @(negedge clk);
        bus0.data_rd_bus = 32'hCAFE_0123;
        chk1("w0_access_en1", bus0.data1_bus_en, 1'b1);
        chk1("w0_access_ack", bus0.ack, 1'b0);
        @(negedge clk);
        bus0.data_rd_bus = $urandom;
        chk1("w0_ack", bus0.ack, 1'b1);
        chk32("w0_rdata", bus0.rdata, 32'hCAFE_0123);
        chk1("w0_done_en1", bus0.data1_bus_en, 1'b0);
        @(negedge clk);
        chk1("w0_ack_drop", bus0.ack, 1'b0);
        chk32("w0_rdata_held", bus0.rdata, 32'hCAFE_0123);
        chk1("w0_idle_busy", bus0.busy, 1'b0);

        // Reset in the middle of ACCESS: everything drops before the next clock edge, access abandoned.
        @(negedge clk);
        bus.req = 1'b1; bus.write = 1'b0; bus.addr = 32'h0001_0030;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk1("pre_rst_en2", bus.data2_bus_en, 1'b1);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            chk1("rst_no_ack", bus.ack, 1'b0);
            chk1("rst_idle_busy", bus.busy, 1'b0);
        end
        last_load = 32'h0;
        a = 32'h0000_0010;
        do_access(1'b0, a, 32'h0, 1'b0, ref_mem.exists(a) ? ref_mem[a] : 32'h0, "post_rst_load");

        for (int i = 0; i < 1000; i++) begin
            w    = 1'($urandom_range(0, 1));
            bank = 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, 15)) << 2;
            a[16] = bank;
            d    = $urandom;
            if (w) exp_rd = last_load;
            else   exp_rd = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            do_access(w, a, d, bank, exp_rd, "rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        chk32("ack_count", 32'(n_ack), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
